// File: rtl/serial_sub_handshake.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_handshake
// Brief    : Bit-serial WIDTH-bit subtractor (O = I0 - I1), LSB first, one bit
//            per clock, with valid/ready handshakes on both sides.
//            Optional macro SERIAL_SUB_SATURATE_EN clamps underflow to zero.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub_handshake #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] O,
  output logic             BORROW
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_o;
  logic             r_br;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;

  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_shift;
  logic [WIDTH-1:0] w_o_load;

  // Full-subtractor bit slice on the current LSBs and the borrow flop.
  assign w_d         = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next   = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
  assign w_last      = (r_cnt == c_cnt_last);
  // Difference bits enter at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign w_res_shift = {w_d, r_res};

`ifdef SERIAL_SUB_SATURATE_EN
  assign w_o_load = w_br_next ? '0 : w_res_shift;
`else
  assign w_o_load = w_res_shift;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (I_VALID) w_state_next = ST_RUN;
      ST_RUN:  if (w_last)  w_state_next = ST_DONE;
      ST_DONE: if (O_READY) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_o      <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (I_VALID) begin
            r_a   <= I0;
            r_b   <= I1;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
          end
        end
        ST_RUN: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_res <= w_res_shift[WIDTH-1:1];
          r_br  <= w_br_next;
          r_cnt <= r_cnt + c_cnt_one;
          if (w_last) begin
            r_o      <= w_o_load;
            r_borrow <= w_br_next;
          end
        end
        default: begin
          // DONE: result registers hold until the consumer accepts.
        end
      endcase
    end
  end

  assign I_READY = (r_state == ST_IDLE);
  assign O_VALID = (r_state == ST_DONE);
  assign O       = r_o;
  assign BORROW  = r_borrow;

endmodule
`default_nettype wire
